// File: rtl/volt_disp_pkg.sv
// Shared types and constants for the voltmeter display controller.
//   state_t     : controller FSM states
//   bcd_digit_t : one BCD digit
//   CV_W/CV_MAX : centivolt value width and saturation ceiling
package volt_disp_pkg;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    SCALE = 2'd1,
    BCD   = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int CV_W   = 14;
  localparam int CV_MAX = 9999;

endpackage

// File: rtl/volt_disp_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter, 14-bit binary to four BCD digits.
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   start, bin       : load request and value; start is ignored while running
//   done             : high in the last iteration cycle (14th after start)
//   dig3..dig0       : result digits (thousands..ones), valid while done is high
module bin2bcd_seq
  import volt_disp_pkg::*;
(
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            start,
  input  logic [CV_W-1:0] bin,
  output logic            done,
  output logic [3:0]      dig3,
  output logic [3:0]      dig2,
  output logic [3:0]      dig1,
  output logic [3:0]      dig0
);

  logic                 running;
  logic [3:0]           iter;
  logic [CV_W-1:0]      bin_sh;
  logic [15:0]          bcd_sh;
  logic [15:0]          bcd_adj;
  logic [CV_W+15:0]     sh_nxt;

  always_comb begin
    bcd_adj = bcd_sh;
    for (int i = 0; i < 4; i++) begin
      if (bcd_sh[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
    end
    sh_nxt = {bcd_adj, bin_sh} << 1;
  end

  // Digits come from the combinational next value so the result is available
  // in the same cycle that the final shift happens.
  assign done = running && (iter == 4'd0);
  assign dig3 = sh_nxt[CV_W+15:CV_W+12];
  assign dig2 = sh_nxt[CV_W+11:CV_W+8];
  assign dig1 = sh_nxt[CV_W+7:CV_W+4];
  assign dig0 = sh_nxt[CV_W+3:CV_W];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      running <= 1'b0;
      iter    <= '0;
      bin_sh  <= '0;
      bcd_sh  <= '0;
    end else if (!running) begin
      if (start) begin
        running <= 1'b1;
        iter    <= 4'(CV_W - 1);
        bin_sh  <= bin;
        bcd_sh  <= '0;
      end
    end else begin
      bcd_sh <= sh_nxt[CV_W+15:CV_W];
      bin_sh <= sh_nxt[CV_W-1:0];
      if (iter == 4'd0)
        running <= 1'b0;
      else
        iter <= iter - 4'd1;
    end
  end

endmodule

// File: rtl/volt_disp_ctrl.sv
// Voltmeter display controller: block-averages signed ADC samples, scales to
// centivolts, converts to BCD and publishes the digits on frame_start.
// Ports:
//   sys_clk, sys_rst     : clock, synchronous active-high reset
//   adc_valid, adc_data  : signed sample stream (dropped while busy)
//   frame_start          : LCD frame pulse, publishes a pending result
//   data_symbol          : 1 = show minus sign
//   data_tens..data_percentiles : BCD digits, zero-extended to 8 bits
//   disp_upd             : one-cycle pulse when the outputs load
//   busy                 : high while scaling / converting
//
// state | meaning
// ACC   | accumulating samples of the current block
// SCALE | average, magnitude, scale and saturate (one cycle)
// BCD   | waiting for the 14-cycle BCD conversion
module volt_disp_ctrl
  import volt_disp_pkg::*;
#(
  parameter int IN_W        = 12,
  parameter int AVG_LOG2    = 4,
  parameter int SCALE_MUL   = 1001,
  parameter int SCALE_SHIFT = 11
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            adc_valid,
  input  logic [IN_W-1:0] adc_data,
  input  logic            frame_start,
  output logic            data_symbol,
  output logic [7:0]      data_tens,
  output logic [7:0]      data_units,
  output logic [7:0]      data_decile,
  output logic [7:0]      data_percentiles,
  output logic            disp_upd,
  output logic            busy
);

  localparam int ACC_W  = IN_W + AVG_LOG2;
  localparam int PROD_W = IN_W + 16;

  state_t state, state_nxt;

  logic signed [ACC_W-1:0] acc;
  logic [AVG_LOG2-1:0]     cnt;
  logic                    sample_en;
  logic                    last_sample;
  logic                    scale_start;
  logic                    busy_nxt;

  logic signed [IN_W-1:0]  avg;
  logic [IN_W-1:0]         mag;
  logic [PROD_W-1:0]       prod;
  logic [PROD_W-1:0]       shifted;
  logic [CV_W-1:0]         cv;
  logic                    neg_calc;
  logic                    neg_r;

  logic                    bcd_done;
  bcd_digit_t              d3, d2, d1, d0;

  logic                    pending;
  logic                    sh_neg;
  bcd_digit_t              sh_d3, sh_d2, sh_d1, sh_d0;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ACC;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (last_sample) state_nxt = SCALE;
      SCALE:   state_nxt = BCD;
      BCD:     if (bcd_done) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_comb begin
    sample_en   = adc_valid && (state == ACC);
    scale_start = (state == SCALE);
    busy_nxt    = (state_nxt != ACC);
  end

  // cnt is a down-counter of remaining samples; the block ends at zero.
  assign last_sample = sample_en && (cnt == '0);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || bcd_done) begin
      acc <= '0;
      cnt <= '1;
    end else if (sample_en) begin
      acc <= acc + {{AVG_LOG2{adc_data[IN_W-1]}}, adc_data};
      cnt <= cnt - 1'b1;
    end
  end

  // Magnitude of the most negative average still fits as unsigned IN_W bits.
  always_comb begin
    avg      = IN_W'(acc >>> AVG_LOG2);
    mag      = avg[IN_W-1] ? (~avg + IN_W'(1)) : avg;
    prod     = PROD_W'(mag) * PROD_W'(SCALE_MUL);
    shifted  = prod >> SCALE_SHIFT;
    cv       = (shifted > PROD_W'(CV_MAX)) ? CV_W'(CV_MAX) : shifted[CV_W-1:0];
    neg_calc = avg[IN_W-1] && (cv != '0);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      neg_r <= 1'b0;
      busy  <= 1'b0;
    end else begin
      if (scale_start) neg_r <= neg_calc;
      busy <= busy_nxt;
    end
  end

  bin2bcd_seq u_bcd (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (scale_start),
    .bin     (cv),
    .done    (bcd_done),
    .dig3    (d3),
    .dig2    (d2),
    .dig1    (d1),
    .dig0    (d0)
  );

  // Outputs load from the pre-write shadow, so a coincident result write
  // stays pending for the following frame.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pending          <= 1'b0;
      sh_neg           <= 1'b0;
      sh_d3            <= '0;
      sh_d2            <= '0;
      sh_d1            <= '0;
      sh_d0            <= '0;
      data_symbol      <= 1'b0;
      data_tens        <= '0;
      data_units       <= '0;
      data_decile      <= '0;
      data_percentiles <= '0;
      disp_upd         <= 1'b0;
    end else begin
      disp_upd <= 1'b0;
      if (frame_start && pending) begin
        data_symbol      <= sh_neg;
        data_tens        <= {4'd0, sh_d3};
        data_units       <= {4'd0, sh_d2};
        data_decile      <= {4'd0, sh_d1};
        data_percentiles <= {4'd0, sh_d0};
        disp_upd         <= 1'b1;
        pending          <= 1'b0;
      end
      if (bcd_done) begin
        sh_neg  <= neg_r;
        sh_d3   <= d3;
        sh_d2   <= d2;
        sh_d1   <= d1;
        sh_d0   <= d0;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_volt_disp_ctrl.sv
module tb_volt_disp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        adc_valid, adc_valid2;
  logic [11:0] adc_data, adc_data2;
  logic        fs, fs2;
  logic        sym, sym2, upd, upd2, busy, busy2;
  logic [7:0]  tens, units, dec, pct;
  logic [7:0]  tens2, units2, dec2, pct2;

  always #5 clk = ~clk;

  volt_disp_ctrl dut (
    .sys_clk(clk), .sys_rst(rst), .adc_valid(adc_valid), .adc_data(adc_data),
    .frame_start(fs), .data_symbol(sym), .data_tens(tens), .data_units(units),
    .data_decile(dec), .data_percentiles(pct), .disp_upd(upd), .busy(busy)
  );

  volt_disp_ctrl #(.SCALE_MUL(20000)) dut_sat (
    .sys_clk(clk), .sys_rst(rst), .adc_valid(adc_valid2), .adc_data(adc_data2),
    .frame_start(fs2), .data_symbol(sym2), .data_tens(tens2), .data_units(units2),
    .data_decile(dec2), .data_percentiles(pct2), .disp_upd(upd2), .busy(busy2)
  );

  typedef struct packed {
    logic       sym;
    logic [7:0] t;
    logic [7:0] u;
    logic [7:0] d;
    logic [7:0] p;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(input int cv, input bit neg);
    exp_t e;
    e.sym = neg;
    e.t   = 8'(cv / 1000);
    e.u   = 8'((cv / 100) % 10);
    e.d   = 8'((cv / 10) % 10);
    e.p   = 8'(cv % 10);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: every disp_upd pulse must match the oldest expected publish.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && upd) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_upd: got pulse expected none at %0t", $time);
      end else begin
        e = q1.pop_front();
        chk("pub_symbol", sym, e.sym);
        chk("pub_tens", tens, e.t);
        chk("pub_units", units, e.u);
        chk("pub_decile", dec, e.d);
        chk("pub_percentiles", pct, e.p);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && upd2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_upd_sat: got pulse expected none at %0t", $time);
      end else begin
        e = q2.pop_front();
        chk("sat_symbol", sym2, e.sym);
        chk("sat_tens", tens2, e.t);
        chk("sat_units", units2, e.u);
        chk("sat_decile", dec2, e.d);
        chk("sat_percentiles", pct2, e.p);
      end
    end
  end

  task automatic sample1(input logic [11:0] v);
    @(negedge clk);
    adc_valid = 1'b1;
    adc_data  = v;
    fs        = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      adc_valid = 1'b0;
      fs        = 1'b0;
    end
  endtask

  task automatic block(input logic [11:0] v);
    for (int i = 0; i < 16; i++) sample1(v);
    idle(20);
  endtask

  task automatic publish(input exp_t e, input bit expect_upd);
    if (expect_upd) q1.push_back(e);
    @(negedge clk);
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    chk("upd_at_f1", upd, expect_upd);
    @(negedge clk);
    chk("upd_one_cycle", upd, 0);
  endtask

  initial begin
    rst = 1'b1;
    adc_valid = 1'b0; adc_data = '0; fs = 1'b0;
    adc_valid2 = 1'b0; adc_data2 = '0; fs2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_symbol", sym, 0);
    chk("rst_digits", {tens, units, dec, pct}, 0);
    chk("rst_upd", upd, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    idle(2);

    // 1024 -> 500 cV, then an empty frame
    block(12'd1024);
    publish(mk(500, 0), 1);
    publish(mk(0, 0), 0);

    // -2048 -> 1001 cV negative
    block(12'h800);
    publish(mk(1001, 1), 1);

    // 15 x 0 and one -1 -> no negative zero
    for (int i = 0; i < 15; i++) sample1(12'd0);
    sample1(12'hFFF);
    idle(20);
    publish(mk(0, 0), 1);

    // latest result wins
    block(12'd1024);
    block(12'd512);
    publish(mk(250, 0), 1);
    publish(mk(0, 0), 0);

    // busy window and samples dropped while busy
    for (int i = 0; i < 16; i++) sample1(12'd1024);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      adc_valid = 1'b1;
      adc_data  = 12'h800;
      chk("busy_high", busy, 1);
    end
    @(negedge clk);
    chk("busy_low_n16", busy, 0);
    adc_valid = 1'b1;
    adc_data  = 12'd256;
    for (int i = 0; i < 15; i++) begin
      sample1(12'd256);
      chk("busy_low_acc", busy, 0);
    end
    @(negedge clk);
    adc_valid = 1'b0;
    chk("busy_after_16", busy, 1);
    idle(20);
    publish(mk(125, 0), 1);

    // frame_start coincident with shadow write
    block(12'd1024);
    for (int i = 0; i < 16; i++) sample1(12'h800);
    idle(14);
    q1.push_back(mk(500, 0));
    @(negedge clk);
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    chk("coincident_upd", upd, 1);
    idle(5);
    publish(mk(1001, 1), 1);

    // reset in the middle of BCD conversion
    for (int i = 0; i < 16; i++) sample1(12'd512);
    idle(7);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_symbol", sym, 0);
    chk("midrst_digits", {tens, units, dec, pct}, 0);
    chk("midrst_upd", upd, 0);
    chk("midrst_busy", busy, 0);
    idle(20);
    publish(mk(0, 0), 0);
    block(12'd512);
    publish(mk(250, 0), 1);

    // saturation with a large multiplier
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      adc_valid2 = 1'b1;
      adc_data2  = 12'd2047;
    end
    @(negedge clk);
    adc_valid2 = 1'b0;
    repeat (20) @(negedge clk);
    q2.push_back(mk(9999, 0));
    fs2 = 1'b1;
    @(negedge clk);
    fs2 = 1'b0;
    chk("sat_upd", upd2, 1);

    idle(5);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
